ps2_key_ctrl: RTL and testbench
===============================

Name: ps2_key_ctrl

Overview:
- Sits between the ps2_kbd receiver and the CPU bus slave port.
- Sequences the receiver's ready/rdn pop handshake and folds E0 (extended) and F0 (break) prefix bytes into single key-event words.
- Buffers events in a FIFO and serves them through a two-register memory-mapped interface (DATA, STATUS) with a registered ack.

Parameters:
FIFO_DEPTH, 8, number of event entries; power of two, minimum 2.
CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy counter.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
clrn  in  1  reset; synchronous, active-low.
stb_i  in  1  bus strobe; held high until ack_o is seen.
we_i  in  1  1 = write, 0 = read.
adr_i  in  32  byte address; only adr_i[2] is decoded (0 = DATA, 1 = STATUS).
dat_i  in  32  write data.
dat_o  out  32  read data; registered and valid in the ack_o cycle.
ack_o  out  1  registered single-cycle acknowledge.
kbd_data  in  8  byte from ps2_kbd.
kbd_ready  in  1  ps2_kbd holds a byte.
kbd_overflow  in  1  ps2_kbd internal overflow flag.
kbd_rdn  out  1  active-low pop strobe to ps2_kbd.
irq  out  1  interrupt; present only with PS2_IRQ_EN.

Behaviour:
- Reset (clrn=0 at a clk edge):
  - kbd_rdn=1; ack_o=0; dat_o=0; irq=0.
  - FIFO empty, count=0; ext/brk flags cleared; overflow cleared; irq_mask=0; FSM in IDLE.
  - Reset mid-sequence abandons any partially assembled prefix.
- Receiver FSM, states IDLE, POP, GAP:
  - IDLE: when kbd_ready=1, latch kbd_data into byte_r, drive kbd_rdn=0 for the next cycle, go to POP.
  - POP: kbd_rdn=0 for exactly one cycle; process byte_r; go to GAP.
  - GAP: kbd_rdn=1 for one cycle so the receiver can update ready; return to IDLE.
  - Maximum throughput is one byte per 3 cycles.
- Byte processing:
  - 8'hE0 sets ext=1. 8'hF0 sets brk=1. Neither pushes an event.
  - Any other byte pushes event {ext, brk, code} (10 bits), then clears ext and brk.
  - A repeated prefix keeps its flag set.
- FIFO rules:
  - Push while full without a same-cycle pop: the event is dropped and overflow is set (sticky).
  - Push and pop in the same cycle are both performed, even when full or empty-with-push. Count is unchanged, except that empty plus push gives count=1.
  - Pointers wrap modulo FIFO_DEPTH.
  - kbd_overflow=1 on any cycle also sets overflow.
- Bus handshake:
  - ack_o <= stb_i & ~ack_o, so each transaction gets exactly one ack_o pulse, one cycle after strobe sampling.
  - Side effects occur only on the edge where ack_o is set. Back-to-back transactions therefore take 2 cycles each.
- Read DATA:
  - dat_o = {valid, 21'b0, ext, brk, code}, with valid = FIFO non-empty.
  - The FIFO pops when non-empty.
  - When empty, dat_o = 0 and no pop occurs.
- Read STATUS:
  - dat_o[0] = non-empty.
  - dat_o[1] = full.
  - dat_o[2] = overflow.
  - dat_o[4] = irq_mask.
  - dat_o[8+:CNT_W] = count.
  - All other bits read 0. A STATUS read has no side effects.
- Write DATA:
  - dat_i[0]=1 flushes the FIFO and clears ext and brk.
  - Flush wins over a same-cycle push; that event is discarded.
- Write STATUS:
  - dat_i[2]=1 clears overflow. A same-cycle overflow set wins over the clear.
  - dat_i[4] loads irq_mask.

Optional Feature:
PS2_IRQ_EN
- Defined: irq port exists; irq is registered as irq_mask & (non-empty | overflow), one cycle after the condition.
- Undefined: irq port absent, irq_mask register absent, STATUS bit 4 reads 0 and writes to it are ignored.

Decomposition:
- Package ps2_pkg holds:
  - FSM state enum (IDLE, POP, GAP).
  - Constants PS2_PFX_EXT=8'hE0 and PS2_PFX_BRK=8'hF0.
  - Register offsets REG_DATA=0 and REG_STATUS=1.
  - STATUS bit indices.
  - Event width EVT_W=10 and an event struct {ext, brk, code}.
- One sub-module, ps2_evt_fifo: synchronous FIFO parameterised by depth and width, with push, pop, flush, full, empty and count.

Test Plan:
1. After reset, STATUS read -> ack_o one cycle after stb_i, dat_o=0, kbd_rdn=1.
2. Feed bytes 1C, F0, 1C -> kbd_rdn pulses low one cycle per byte.
   - First DATA read: 32'h8000001C.
   - Second DATA read: 32'h8000011C.
   - Third DATA read: 0.
3. Feed E0, F0, 75 -> DATA read 32'h80000375, STATUS count returns to 0.
4. Feed 9 non-prefix bytes with FIFO_DEPTH=8 -> STATUS reads 32'h00000807 (count 8, overflow, full, non-empty).
   - The 9th byte is lost.
   - Writing STATUS with 32'h4 then reading gives 32'h00000803.
5. Land a push and a DATA read pop on the same edge with count=3 -> count stays 3 and event order is preserved.
   - Write DATA with 1 while a push lands -> count 0.
6. With PS2_IRQ_EN: write STATUS 32'h10, then feed byte 29 -> irq=1.
   - DATA read returns 32'h80000029 and irq returns to 0 on the following cycle.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key controller: receiver FSM states,
// prefix bytes, register map, STATUS bit positions and the key-event word.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    GAP
  } rx_state_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int ST_NEMPTY   = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_OVF      = 2;
  localparam int ST_IRQ_MASK = 4;
  localparam int ST_COUNT    = 8;

  localparam int EVT_W = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_PFX_EXT) || (b == PS2_PFX_BRK);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO with flush. A pop on empty is ignored; a push on full
// is accepted only when a real pop frees a slot on the same edge.
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!clrn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 key controller: pops bytes from ps2_kbd, folds E0/F0 prefixes into key
// events, buffers them and serves DATA/STATUS over the bus. Macro PS2_IRQ_EN adds irq.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_ready,
  input  logic        kbd_overflow,
  output logic        kbd_rdn
`ifdef PS2_IRQ_EN
  ,
  output logic        irq
`endif
);

  rx_state_t        state;
  rx_state_t        state_next;
  logic [7:0]       byte_r;
  logic             ext;
  logic             brk;
  logic             ovf;
  logic             mask_bit;
  evt_t             evt_in;
  logic [EVT_W-1:0] head;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic [31:0]      rd_word;
  logic             unused;

  // Side effects happen only on the edge that raises ack_o.
  logic access, is_status, rd_data, wr_data, wr_status, flush, push_evt, push, pop;
  assign access    = stb_i & ~ack_o;
  assign is_status = (adr_i[2] == REG_STATUS);
  assign rd_data   = access & ~we_i & ~is_status;
  assign wr_data   = access &  we_i & ~is_status;
  assign wr_status = access &  we_i &  is_status;
  assign flush     = wr_data & dat_i[0];
  assign pop       = rd_data & ~empty;
  assign push_evt  = (state == POP) & ~is_prefix(byte_r);
  assign push      = push_evt & ~flush;
  assign evt_in    = '{ext: ext, brk: brk, code: byte_r};
  assign unused    = ^{adr_i, dat_i};

  always_ff @(posedge clk) begin
    if (!clrn) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    kbd_rdn    = 1'b1;
    case (state)
      IDLE: if (kbd_ready) state_next = POP;
      POP: begin
        kbd_rdn    = 1'b0;
        state_next = GAP;
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      byte_r <= '0;
      ext    <= 1'b0;
      brk    <= 1'b0;
    end else begin
      if (state == IDLE && kbd_ready) byte_r <= kbd_data;
      if (flush) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (state == POP) begin
        if (byte_r == PS2_PFX_EXT) ext <= 1'b1;
        else if (byte_r == PS2_PFX_BRK) brk <= 1'b1;
        else begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end

  // Setting overflow takes priority over a same-edge clear from software.
  always_ff @(posedge clk) begin
    if (!clrn) ovf <= 1'b0;
    else if ((push & full & ~pop) | kbd_overflow) ovf <= 1'b1;
    else if (wr_status & dat_i[ST_OVF]) ovf <= 1'b0;
  end

`ifdef PS2_IRQ_EN
  always_ff @(posedge clk) begin
    if (!clrn) begin
      mask_bit <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_status) mask_bit <= dat_i[ST_IRQ_MASK];
      irq <= mask_bit & (~empty | ovf);
    end
  end
`else
  assign mask_bit = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    if (is_status) begin
      rd_word[ST_NEMPTY]          = ~empty;
      rd_word[ST_FULL]            = full;
      rd_word[ST_OVF]             = ovf;
      rd_word[ST_IRQ_MASK]        = mask_bit;
      rd_word[ST_COUNT +: CNT_W]  = count;
    end else if (!empty) begin
      rd_word = {1'b1, {(31 - EVT_W){1'b0}}, head};
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      ack_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= stb_i & ~ack_o;
      if (access) dat_o <= we_i ? 32'h0 : rd_word;
    end
  end

  ps2_evt_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EVT_W),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk  (clk),
    .clrn (clrn),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .wdata(evt_in),
    .rdata(head),
    .full (full),
    .empty(empty),
    .count(count)
  );

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: directed vector table, hand-timed same-edge corner cases
// and a randomized phase checked against a queue-based event model.
module tb_ps2_key_ctrl;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef PS2_IRQ_EN
  localparam logic [31:0] MASK_STATUS = 32'h10;
`else
  localparam logic [31:0] MASK_STATUS = 32'h00;
`endif

  logic        clk = 1'b0;
  logic        clrn;
  logic        stb_i, we_i;
  logic [31:0] adr_i, dat_i, dat_o;
  logic        ack_o;
  logic [7:0]  kbd_data;
  logic        kbd_ready, kbd_overflow, kbd_rdn;
`ifdef PS2_IRQ_EN
  logic        irq;
`endif

  ps2_key_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .stb_i       (stb_i),
    .we_i        (we_i),
    .adr_i       (adr_i),
    .dat_i       (dat_i),
    .dat_o       (dat_o),
    .ack_o       (ack_o),
    .kbd_data    (kbd_data),
    .kbd_ready   (kbd_ready),
    .kbd_overflow(kbd_overflow),
    .kbd_rdn     (kbd_rdn)
`ifdef PS2_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fed    = 0;
  int rdn_pulses  = 0;
  int long_pulses = 0;
  logic prev_low  = 1'b0;
  logic [7:0] rx_q[$];

  // Receiver stand-in: a low kbd_rdn seen mid-cycle consumes the head byte.
  always @(negedge clk) begin
    if (kbd_rdn === 1'b0) begin
      if (prev_low) long_pulses++;
      rdn_pulses++;
      if (rx_q.size() > 0) rx_q.delete(0);
    end
    prev_low  = (kbd_rdn === 1'b0);
    kbd_ready = (rx_q.size() > 0);
    kbd_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  // Reference model: event queue plus prefix and status flags.
  logic [9:0] m_q[$];
  logic m_ext, m_brk, m_ovf, m_mask;

  task automatic m_reset();
    m_q.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_mask = 0;
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (m_q.size() < DEPTH) m_q.push_back({m_ext, m_brk, b});
      else m_ovf = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic m_flush();
    m_q.delete();
    m_ext = 0; m_brk = 0;
  endtask

  function automatic logic [31:0] m_read_data();
    logic [31:0] v = 32'h0;
    if (m_q.size() > 0) begin
      v = {1'b1, 21'b0, m_q[0]};
      m_q.delete(0);
    end
    return v;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] v = 32'h0;
    v[0] = (m_q.size() > 0);
    v[1] = (m_q.size() == DEPTH);
    v[2] = m_ovf;
    v[4] = m_mask;
    v[8 +: CNT_W] = CNT_W'(m_q.size());
    return v;
  endfunction

  task automatic m_write_status(input logic [31:0] w);
    if (w[2]) m_ovf = 1'b0;
`ifdef PS2_IRQ_EN
    m_mask = w[4];
`endif
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp_v);
  endtask

  task automatic rx_feed(input logic [7:0] b);
    rx_q.push_back(b);
    n_fed++;
  endtask

  task automatic feed(input logic [7:0] b);
    rx_feed(b);
    m_byte(b);
  endtask

  task automatic wait_rx();
    int n = 0;
    while (rx_q.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("rx_drain", rx_q.size(), 0);
    rx_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // One bus transaction; entered and left 1 time unit after a rising edge.
  task automatic bus(input logic we, input logic adr2, input logic [31:0] wd,
                     output logic [31:0] rd);
    int lat = 0;
    stb_i = 1'b1; we_i = we; adr_i = {29'b0, adr2, 2'b0}; dat_i = wd;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack_o && lat < 4);
    check("ack_latency", lat, 1);
    rd = dat_o;
    stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk); #1;
    check("ack_single", ack_o, 0);
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 5))
      0:       return 8'hE0;
      1:       return 8'hF0;
      default: return 8'($urandom);
    endcase
  endfunction

  typedef enum logic [1:0] {OP_FEED, OP_RD, OP_WR} op_e;
  typedef struct {
    op_e         op;
    logic        adr2;
    logic [31:0] data;
    logic [31:0] exp_v;
    string       name;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(op_e op, logic adr2, logic [31:0] d, logic [31:0] e, string nm);
    vecs.push_back('{op, adr2, d, e, nm});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, w, exp_v;
    int op, nb;

    clrn = 1'b0; stb_i = 0; we_i = 0; adr_i = 0; dat_i = 0; kbd_overflow = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_kbd_rdn", kbd_rdn, 1);
    check("rst_ack", ack_o, 0);
    check("rst_dat", dat_o, 0);
    clrn = 1'b1;

    add(OP_RD, 1, 0, 32'h0, "status_after_reset");
    add(OP_FEED, 0, 8'h1C, 0, ""); add(OP_FEED, 0, 8'hF0, 0, ""); add(OP_FEED, 0, 8'h1C, 0, "");
    add(OP_RD, 0, 0, 32'h8000001C, "make_1c");
    add(OP_RD, 0, 0, 32'h8000011C, "break_1c");
    add(OP_RD, 0, 0, 32'h00000000, "empty_read");
    add(OP_FEED, 0, 8'hE0, 0, ""); add(OP_FEED, 0, 8'hF0, 0, ""); add(OP_FEED, 0, 8'h75, 0, "");
    add(OP_RD, 0, 0, 32'h80000375, "ext_break_75");
    add(OP_RD, 1, 0, 32'h0, "status_drained");
    for (int k = 1; k <= 9; k++) add(OP_FEED, 0, k, 0, "");
    add(OP_RD, 1, 0, 32'h00000807, "status_full_ovf");
    add(OP_WR, 1, 32'h4, 0, "");
    add(OP_RD, 1, 0, 32'h00000803, "status_ovf_cleared");
    for (int k = 1; k <= 8; k++) add(OP_RD, 0, 0, 32'h80000000 | k, "full_drain");
    add(OP_RD, 0, 0, 32'h0, "ninth_lost");
    add(OP_FEED, 0, 8'hE0, 0, ""); add(OP_FEED, 0, 8'hE0, 0, ""); add(OP_FEED, 0, 8'h6B, 0, "");
    add(OP_RD, 0, 0, 32'h8000026B, "repeat_prefix");
    add(OP_FEED, 0, 8'h33, 0, ""); add(OP_FEED, 0, 8'hF0, 0, "");
    add(OP_WR, 0, 32'h1, 0, "");
    add(OP_FEED, 0, 8'h12, 0, "");
    add(OP_RD, 0, 0, 32'h80000012, "flush_clears_prefix");
    add(OP_RD, 0, 0, 32'h0, "flush_emptied");
    add(OP_WR, 1, 32'h10, 0, "");
    add(OP_RD, 1, 0, MASK_STATUS, "mask_bit");
    add(OP_WR, 1, 32'h0, 0, "");

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_FEED: rx_feed(vecs[i].data[7:0]);
        OP_RD: begin
          wait_rx();
          bus(1'b0, vecs[i].adr2, 32'h0, rd);
          check(vecs[i].name, rd, vecs[i].exp_v);
        end
        default: begin
          wait_rx();
          bus(1'b1, vecs[i].adr2, vecs[i].data, rd);
        end
      endcase
    end
    check("rdn_pulses_table", rdn_pulses, n_fed);

    // Push and DATA pop on the same edge with three events queued.
    m_reset();
    feed(8'h11); feed(8'h22); feed(8'h33); wait_rx();
    rx_feed(8'h44); @(negedge clk); @(posedge clk); #1;
    bus(1'b0, 1'b0, 32'h0, rd);
    check("same_edge_pop", rd, 32'h80000011);
    exp_v = m_read_data(); m_byte(8'h44);
    wait_rx();
    bus(1'b0, 1'b1, 32'h0, rd); check("same_edge_count", rd, 32'h00000301);
    for (int k = 0; k < 3; k++) begin
      bus(1'b0, 1'b0, 32'h0, rd); check("same_edge_order", rd, m_read_data());
    end

    // Same-edge push and pop while full: both happen, no overflow.
    for (int k = 0; k < 8; k++) feed(8'h50 + 8'(k));
    wait_rx();
    rx_feed(8'h58); @(negedge clk); @(posedge clk); #1;
    bus(1'b0, 1'b0, 32'h0, rd); check("full_same_edge_pop", rd, 32'h80000050);
    exp_v = m_read_data(); m_byte(8'h58);
    wait_rx();
    bus(1'b0, 1'b1, 32'h0, rd); check("full_same_edge_status", rd, 32'h00000803);
    for (int k = 1; k <= 8; k++) begin
      bus(1'b0, 1'b0, 32'h0, rd); check("full_same_edge_order", rd, 32'h80000050 + k);
    end

    // Flush landing on the same edge as a push discards that event.
    feed(8'h61); feed(8'h62); feed(8'h63); wait_rx();
    rx_feed(8'h66); @(negedge clk); @(posedge clk); #1;
    bus(1'b1, 1'b0, 32'h1, rd);
    wait_rx();
    bus(1'b0, 1'b1, 32'h0, rd); check("flush_wins_status", rd, 32'h0);
    bus(1'b0, 1'b0, 32'h0, rd); check("flush_wins_data", rd, 32'h0);

    // kbd_overflow on the clearing edge keeps overflow set.
    stb_i = 1; we_i = 1; adr_i = 32'h4; dat_i = 32'h4; kbd_overflow = 1;
    @(posedge clk); #1;
    kbd_overflow = 0;
    check("ovf_prio_ack", ack_o, 1);
    stb_i = 0; we_i = 0;
    @(posedge clk); #1;
    bus(1'b0, 1'b1, 32'h0, rd); check("ovf_set_wins", rd, 32'h4);
    bus(1'b1, 1'b1, 32'h4, rd);
    bus(1'b0, 1'b1, 32'h0, rd); check("ovf_cleared", rd, 32'h0);

    // Reset with a prefix pending abandons it and clears dat_o.
    m_reset();
    feed(8'h5A); feed(8'hE0); wait_rx();
    bus(1'b0, 1'b0, 32'h0, rd); check("pre_reset_data", rd, 32'h8000005A);
    clrn = 1'b0; @(posedge clk); #1; clrn = 1'b1;
    check("mid_rst_dat", dat_o, 0);
    check("mid_rst_rdn", kbd_rdn, 1);
    m_reset();
    feed(8'h1C); wait_rx();
    bus(1'b0, 1'b0, 32'h0, rd); check("prefix_abandoned", rd, m_read_data());

    // Randomized traffic against the model.
    bus(1'b1, 1'b0, 32'h1, rd);
    bus(1'b1, 1'b1, 32'h4, rd);
    m_reset();
    for (int it = 0; it < 160; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        nb = $urandom_range(1, 4);
        for (int j = 0; j < nb; j++) feed(rand_byte());
      end else begin
        wait_rx();
        if (op <= 6) begin
          exp_v = m_read_data();
          bus(1'b0, 1'b0, 32'h0, rd); check("rand_data", rd, exp_v);
        end else if (op == 7) begin
          bus(1'b0, 1'b1, 32'h0, rd); check("rand_status", rd, m_status());
        end else if (op == 8) begin
          w = $urandom;
          bus(1'b1, 1'b1, w, rd); m_write_status(w);
        end else begin
          w = $urandom;
          if ($urandom_range(0, 3) != 0) w[0] = 1'b0;
          bus(1'b1, 1'b0, w, rd);
          if (w[0]) m_flush();
        end
`ifdef PS2_IRQ_EN
        check("rand_irq", irq, m_mask & ((m_q.size() > 0) | m_ovf));
`endif
      end
    end
    wait_rx();
    bus(1'b0, 1'b1, 32'h0, rd); check("rand_final_status", rd, m_status());

`ifdef PS2_IRQ_EN
    bus(1'b1, 1'b0, 32'h1, rd);
    bus(1'b1, 1'b1, 32'h14, rd);
    check("irq_idle", irq, 0);
    feed(8'h29); wait_rx();
    check("irq_set", irq, 1);
    bus(1'b0, 1'b0, 32'h0, rd); check("irq_data", rd, 32'h80000029);
    check("irq_clear", irq, 0);
`endif

    check("rdn_pulses_total", rdn_pulses, n_fed);
    check("rdn_single_cycle", long_pulses, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
